// File: rtl/lbcnn_pkg.sv
// Shared constants, geometry helpers and stream FSM encoding for the lbcnn readout path.
// The CSUM state exists only when LBCNN_STREAM_CSUM_EN is defined.
package lbcnn_pkg;

    localparam int DATA_W       = 16;
    localparam int DEF_IMG_SIZE = 15;
    localparam int DEF_KER_SIZE = 3;

    // Four valid 3x3-style stages each shrink the map by (ker-1).
    function automatic int out_dim(input int img, input int ker);
        return img - 4 * ker + 4;
    endfunction

    function automatic int fc_size(input int img, input int ker);
        return out_dim(img, ker) * out_dim(img, ker);
    endfunction

    localparam int DEF_OUT_DIM       = out_dim(DEF_IMG_SIZE, DEF_KER_SIZE);
    localparam int DEF_FC_INPUT_SIZE = fc_size(DEF_IMG_SIZE, DEF_KER_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
`ifdef LBCNN_STREAM_CSUM_EN
        , ST_CSUM
`endif
    } stream_state_e;

endpackage

// File: rtl/lbcnn_stream_ctr.sv
// Beat counter for the flattened map: flat index plus row/col counters that
// yield row-end, last-data-word and last-beat flags without any divider.
module lbcnn_stream_ctr #(
    parameter int OUT_DIM = 7,
    parameter int EXTRA   = 0,
    parameter int IDX_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    output logic [IDX_W-1:0] idx_o,
    output logic             row_end_o,
    output logic             data_last_o,
    output logic             last_o
);

    localparam int CW = $clog2(OUT_DIM + 1);
    localparam logic [CW-1:0] COL_MAX = CW'(OUT_DIM - 1);

    logic [CW-1:0]    col_q, col_d, row_q, row_d;
    logic [IDX_W-1:0] idx_q;
    logic             row_end_q, data_last_q, last_q, data_last_d;

    always_comb begin
        col_d       = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
        row_d       = (col_q == COL_MAX) ? row_q + 1'b1 : row_q;
        data_last_d = (row_d == COL_MAX) && (col_d == COL_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            row_end_q   <= 1'b0;
            data_last_q <= 1'b0;
            last_q      <= 1'b0;
        end else if (clr) begin
            idx_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            row_end_q   <= (OUT_DIM == 1);
            data_last_q <= (OUT_DIM == 1);
            last_q      <= (EXTRA == 0) && (OUT_DIM == 1);
        end else if (step) begin
            idx_q       <= idx_q + 1'b1;
            col_q       <= col_d;
            row_q       <= row_d;
            row_end_q   <= (col_d == COL_MAX);
            data_last_q <= data_last_d;
            // With a trailing extra beat, "last" lands one step after the final data word.
            last_q      <= (EXTRA != 0) ? data_last_q : data_last_d;
        end
    end

    assign idx_o       = idx_q;
    assign row_end_o   = row_end_q;
    assign data_last_o = data_last_q;
    assign last_o      = last_q;

endmodule

// File: rtl/lbcnn_fmap_streamer.sv
// Snapshots the lbcnn flattened output and streams it one word per beat over valid/ready.
// Define LBCNN_STREAM_CSUM_EN to append a wraparound checksum beat after the last word.
module lbcnn_fmap_streamer
    import lbcnn_pkg::*;
#(
    parameter int  IMG_SIZE      = DEF_IMG_SIZE,
    parameter int  KER_SIZE      = DEF_KER_SIZE,
    parameter int  DATA_W        = lbcnn_pkg::DATA_W,
    localparam int OUT_DIM       = out_dim(IMG_SIZE, KER_SIZE),
    localparam int FC_INPUT_SIZE = OUT_DIM * OUT_DIM,
    localparam int IDX_W         = $clog2(FC_INPUT_SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] flat_in [FC_INPUT_SIZE],
    output logic                     busy,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic [IDX_W-1:0]         m_index,
    output logic                     m_row_end,
    output logic                     m_last,
    output logic                     done
);

`ifdef LBCNN_STREAM_CSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    stream_state_e            state_q;
    logic signed [DATA_W-1:0] buf_q [FC_INPUT_SIZE];
    logic signed [DATA_W-1:0] m_data_q;
    logic                     m_valid_q, busy_q, done_q;
    logic                     cap, xfer;
    logic [IDX_W-1:0]         cnt_idx, nxt_idx;
    logic                     cnt_row_end, cnt_data_last, cnt_last;
`ifdef LBCNN_STREAM_CSUM_EN
    logic signed [DATA_W-1:0] csum_q;
`endif

    assign cap     = (state_q == ST_IDLE) && start;
    assign xfer    = m_valid_q && m_ready;
    assign nxt_idx = cnt_idx + 1'b1;

    lbcnn_stream_ctr #(
        .OUT_DIM (OUT_DIM),
        .EXTRA   (EXTRA),
        .IDX_W   (IDX_W)
    ) u_ctr (
        .clk         (clk),
        .rst         (rst),
        .clr         (cap),
        .step        (xfer),
        .idx_o       (cnt_idx),
        .row_end_o   (cnt_row_end),
        .data_last_o (cnt_data_last),
        .last_o      (cnt_last)
    );

    // Capture buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (cap) buf_q <= flat_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            m_data_q  <= '0;
`ifdef LBCNN_STREAM_CSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_SEND;
                        m_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        // Word 0 comes straight from the input so it is valid next cycle.
                        m_data_q  <= flat_in[0];
`ifdef LBCNN_STREAM_CSUM_EN
                        csum_q    <= '0;
`endif
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
`ifdef LBCNN_STREAM_CSUM_EN
                        csum_q <= csum_q + m_data_q;
                        if (cnt_data_last) begin
                            state_q  <= ST_CSUM;
                            m_data_q <= csum_q + m_data_q;
                        end else begin
                            m_data_q <= buf_q[nxt_idx];
                        end
`else
                        if (cnt_data_last) begin
                            state_q   <= ST_DONE;
                            m_valid_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            m_data_q <= buf_q[nxt_idx];
                        end
`endif
                    end
                end
`ifdef LBCNN_STREAM_CSUM_EN
                ST_CSUM: begin
                    if (xfer) begin
                        state_q   <= ST_DONE;
                        m_valid_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_index   = cnt_idx;
    assign m_row_end = m_valid_q && cnt_row_end;
    assign m_last    = m_valid_q && cnt_last;
    assign done      = done_q;

endmodule

// File: tb/tb_lbcnn_fmap_streamer.sv
// Directed bench for lbcnn_fmap_streamer; covers the LBCNN_STREAM_CSUM_EN build when defined.
module tb_lbcnn_fmap_streamer;

    localparam int NW = 49;
`ifdef LBCNN_STREAM_CSUM_EN
    localparam int NB = 50;
`else
    localparam int NB = 49;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic m_ready = 1'b0;
    logic signed [15:0] flat [NW];
    logic busy, m_valid, m_row_end, m_last, done;
    logic signed [15:0] m_data;
    logic [5:0] m_index;

    logic signed [15:0] exp_q [64];
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lbcnn_fmap_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flat_in   (flat),
        .busy      (busy),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_index   (m_index),
        .m_row_end (m_row_end),
        .m_last    (m_last),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // mode 0: k+1, mode 1: -(k+1), mode 2: all 0x7FFF
    task automatic set_flat(input int mode);
        for (int k = 0; k < NW; k++)
            flat[k] = (mode == 0) ? 16'(k + 1) : (mode == 1) ? 16'(-(k + 1)) : 16'h7FFF;
    endtask

    task automatic set_exp(input int mode);
        for (int k = 0; k < NW; k++)
            exp_q[k] = (mode == 0) ? 16'(k + 1) : (mode == 1) ? 16'(-(k + 1)) : 16'h7FFF;
        exp_q[NW] = (mode == 0) ? 16'h04C9 : (mode == 1) ? 16'hFB37 : 16'h7FCF;
    endtask

    task automatic start_frame();
        @(negedge clk);
        chk("pre_busy", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_valid", m_valid, 1);
        chk("start_busy", busy, 1);
        chk("start_idx", m_index, 0);
    endtask

    task automatic collect(input int rmode, input int pulse_beat, input string name);
        int beats = 0;
        int done_cnt = 0;
        int post = 0;
        bit stall_prev = 0;
        bit last_prev = 0;
        bit lp;
        bit fin = 0;
        bit pulsed = 0;
        logic signed [15:0] pd;
        logic [5:0] pi;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            start = 1'b0;
            m_ready = (rmode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            lp = last_prev;
            last_prev = 0;
            if (stall_prev) begin
                chk($sformatf("%s_hold_data", name), m_data, pd);
                chk($sformatf("%s_hold_idx", name), m_index, pi);
            end
            if (lp) begin
                chk($sformatf("%s_done_pulse", name), done, 1);
                chk($sformatf("%s_done_busy", name), busy, 1);
                chk($sformatf("%s_done_novalid", name), m_valid, 0);
            end
            if (done) done_cnt++;
            if (m_valid && m_ready) begin
                chk($sformatf("%s_data%0d", name, beats), m_data, exp_q[beats]);
                chk($sformatf("%s_idx%0d", name, beats), m_index, beats);
                chk($sformatf("%s_rowend%0d", name, beats), m_row_end,
                    (beats % 7 == 6) && (beats < NW));
                chk($sformatf("%s_last%0d", name, beats), m_last, beats == NB - 1);
                last_prev = (beats == NB - 1);
                beats++;
            end
            stall_prev = m_valid && !m_ready;
            pd = m_data;
            pi = m_index;
            if (pulse_beat >= 0 && beats == pulse_beat && !pulsed) begin
                start = 1'b1;
                pulsed = 1;
            end
            if (done_cnt > 0) post++;
            if (post >= 3) fin = 1;
            @(negedge clk);
        end
        start = 1'b0;
        chk($sformatf("%s_beats", name), beats, NB);
        chk($sformatf("%s_done_cnt", name), done_cnt, 1);
        chk($sformatf("%s_idle_busy", name), busy, 0);
        chk($sformatf("%s_idle_valid", name), m_valid, 0);
    endtask

    initial begin
        set_flat(0);
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", m_last, 0);
        chk("rst_rowend", m_row_end, 0);
        chk("rst_data", m_data, 0);
        chk("rst_idx", m_index, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_novalid", m_valid, 0);
        end

        set_flat(0); set_exp(0);
        start_frame();
        collect(0, -1, "full");

        set_flat(1); set_exp(1);
        start_frame();
        collect(1, -1, "bp");

        set_flat(0); set_exp(0);
        start_frame();
        set_flat(2);
        collect(0, 20, "iso");

        set_flat(0);
        m_ready = 1'b1;
        start_frame();
        repeat (10) @(negedge clk);
        chk("abort_idx", m_index, 10);
        rst = 1'b0;
        #1;
        chk("abort_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_idx0", m_index, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_nodone", done, 0);
            chk("abort_novalid", m_valid, 0);
        end
        set_exp(0);
        start_frame();
        collect(0, -1, "fresh");

`ifdef LBCNN_STREAM_CSUM_EN
        set_flat(2); set_exp(2);
        start_frame();
        collect(0, -1, "ovf");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lbcnn_fmap_streamer.md
Name: lbcnn_fmap_streamer

Overview:
- Transmit side for the lbcnn flattened output.
- On `start`, snapshots the parallel `output_flat` vector and streams it one word per beat over a valid/ready interface, in index order 0..FC_INPUT_SIZE-1.
- Marks row boundaries of the OUT_DIM x OUT_DIM map and the final beat.
- Sits between the lbcnn core and the downstream FC layer or host readout.

Parameters:
- IMG_SIZE, 15: input image side, matches lbcnn.
- KER_SIZE, 3: kernel side, matches lbcnn.
- DATA_W, 16: signed word width.
- OUT_DIM, IMG_SIZE-4*KER_SIZE+4 (default 7): feature map side; derived, do not override.
- FC_INPUT_SIZE, OUT_DIM*OUT_DIM (default 49): number of words per frame; derived.
- IDX_W, $clog2(FC_INPUT_SIZE+1): index width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: frame request; sampled only in IDLE.
- flat_in, input, DATA_W x FC_INPUT_SIZE (signed unpacked array): lbcnn `output_flat`; captured on accepted start.
- busy, output, 1: high from the cycle after start is accepted through DONE.
- m_valid, output, 1: stream word valid.
- m_ready, input, 1: downstream ready.
- m_data, output, DATA_W signed: current word.
- m_index, output, IDX_W: flat index of current word.
- m_row_end, output, 1: current word is column OUT_DIM-1 of its row.
- m_last, output, 1: current word is the final beat of the frame.
- done, output, 1: one-cycle pulse after the final beat transfers.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, m_valid, m_last, m_row_end and done are 0; m_data and m_index are 0. The capture buffer is not reset.
- FSM states: IDLE, SEND, DONE (plus CSUM when the optional feature is compiled in).
- IDLE:
  - start=1 at edge N: buffer<=flat_in, idx<=0, state->SEND.
  - At N+1: m_valid=1, m_data=buffer[0], busy=1. Fixed 1-cycle start-to-valid latency.
- SEND:
  - Transfer = m_valid & m_ready at a rising edge. On transfer, idx increments.
  - m_data, m_index, m_row_end and m_last are registered and change only on transfer.
  - While m_valid=1 and m_ready=0, all stream outputs hold stable.
  - m_valid never drops mid-frame.
- Index rules:
  - m_row_end=1 when idx mod OUT_DIM == OUT_DIM-1; tracked with separate row/col counters, no divider.
  - m_last=1 when idx == FC_INPUT_SIZE-1.
- Frame end: transfer with m_last=1 -> state=DONE and m_valid=0 on the next cycle.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. Minimum start-to-start spacing is FC_INPUT_SIZE+2 cycles at full throughput.
- start in SEND or DONE is ignored and not queued.
- flat_in changes after capture do not affect the frame in flight.
- m_ready=1 continuously: one word per cycle, no bubbles.
- Reset mid-frame: immediate return to IDLE, m_valid=0, no done pulse; the partial frame is discarded.
- Data is passed through bit-exact; no arithmetic on payload except the optional checksum.

Optional Feature:
- Macro: LBCNN_STREAM_CSUM_EN.
- Defined:
  - After word FC_INPUT_SIZE-1, one extra CSUM beat is sent: m_data = DATA_W-bit wraparound sum of all frame words, two's complement, modulo 2^DATA_W.
  - The CSUM beat has m_index=FC_INPUT_SIZE, m_row_end=0, m_last=1.
  - Word FC_INPUT_SIZE-1 then has m_last=0.
  - The sum accumulates at capture (combinational adder tree) or incrementally per transfer; the value is identical either way.
- Undefined: no CSUM state; frame length is exactly FC_INPUT_SIZE beats.

Decomposition:
- Package lbcnn_pkg:
  - DATA_W localparam.
  - out_dim(img, ker) function.
  - FC_INPUT_SIZE derivation.
  - Stream FSM state enum typedef.
- Sub-module lbcnn_stream_ctr: flat index plus row/col counter; outputs idx, row_end and last flags; advances on a `step` input; clears on `clr`.

Test Plan:
- Reset then idle: rst=0 mid-simulation -> m_valid=0, busy=0, done=0 asynchronously; no beats while start=0.
- Full-rate frame: flat_in[k]=k+1, start one cycle, m_ready=1 ->
  - m_valid rises 1 cycle after start;
  - 49 beats with data 1..49, index 0..48;
  - m_row_end on indices 6,13,...,48; m_last only on index 48;
  - done pulses 1 cycle after beat 48.
- Backpressure: m_ready toggles 1,0,0,1 pattern; flat_in[k]=-(k+1) -> data held stable during stalls; order -1..-49 preserved; still 49 beats.
- Capture isolation and start ignore:
  - change flat_in to all 16'h7FFF after start -> stream still 1..49;
  - pulse start at beat 20 -> no restart, single done.
- Reset mid-frame: assert rst at beat 10 -> m_valid=0 immediately, no done; a new start produces a fresh frame from index 0.
- LBCNN_STREAM_CSUM_EN: flat_in[k]=k+1 -> 50 beats; beat 49 data 16'h04C9 (1225), index 49, m_last=1; beat 48 has m_last=0.
  - Overflow case: all 16'h7FFF -> checksum equals 49*0x7FFF mod 2^16 = 16'h7FCF.
